line_follower_ctrl: RTL and testbench

Parametrised line-following motor controller for the robot top level. It samples an N-wide IR sensor bar, debounces it, and classifies line position from a signed weighted error. A state machine (forward, pivot left/right, lost-line search, stop) drives the H-bridge direction pins, two PWM enables with per-state duty, and the direction LEDs. It sits between the raw sensor pins and the motor-driver and LED pins.

---
 rtl/lf_pkg.sv | 20 ++
 rtl/lf_if.sv | 11 +
 rtl/lf_pwm.sv | 28 ++
 rtl/line_follower_ctrl.sv | 120 ++++++++++++
 tb/tb_line_follower_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/lf_pkg.sv
// lf_pkg: shared state/class types and motor/LED output patterns for the line follower.
package lf_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_FWD, ST_TURN_L, ST_TURN_R, ST_SEARCH, ST_STOP} state_e;
    typedef enum logic [2:0] {CL_LOST, CL_MARK, CL_LEFT, CL_RIGHT, CL_CENTRE} class_e;
    typedef enum logic {DIR_L, DIR_R} dir_e;
    localparam logic [3:0] MOT_OFF   = 4'b0000;
    localparam logic [3:0] MOT_FWD   = 4'b1010;
    localparam logic [3:0] MOT_LEFT  = 4'b0110;
    localparam logic [3:0] MOT_RIGHT = 4'b1001;
    localparam logic [2:0] LED_OFF    = 3'b000;
    localparam logic [2:0] LED_FULL   = 3'b111;
    localparam logic [2:0] LED_SEARCH = 3'b010;
    localparam logic [2:0] LED_STOP   = 3'b101;
    function automatic state_e class_target(class_e c);
        return (c == CL_CENTRE) ? ST_FWD :
               (c == CL_LEFT)   ? ST_TURN_L :
               (c == CL_RIGHT)  ? ST_TURN_R :
               (c == CL_MARK)   ? ST_STOP : ST_SEARCH;
    endfunction
endpackage

// File: rtl/lf_if.sv
// lf_if: sensor bar input and motor-driver/LED outputs of the line follower.
interface lf_if #(parameter int N_SENSORS = 5);
    logic [N_SENSORS-1:0] ir_sensor;
    logic                 left_motor1, left_motor2, right_motor1, right_motor2;
    logic                 ena, enb, LED_ON;
    logic [2:0]           LED_LEFT, LED_RIGHT, LED_STR;
    modport master (input ir_sensor, output left_motor1, left_motor2, right_motor1, right_motor2,
                    output ena, enb, LED_ON, LED_LEFT, LED_RIGHT, LED_STR);
    modport slave (output ir_sensor, input left_motor1, left_motor2, right_motor1, right_motor2,
                   input ena, enb, LED_ON, LED_LEFT, LED_RIGHT, LED_STR);
endinterface

// File: rtl/lf_pwm.sv
// lf_pwm: free-running PWM counter with a duty latch that only updates on wrap.
module lf_pwm #(
    parameter int PWM_PERIOD = 100
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_duty,
    input  logic       i_zero,
    output logic       o_en
);
    logic [7:0] r_cnt, r_duty, w_cnt, w_duty;
    logic       r_en;
    assign w_cnt  = (r_cnt == 8'(PWM_PERIOD - 1)) ? 8'd0 : r_cnt + 8'd1;
    // i_zero kills the duty at once so the enable falls with the motor pins
    assign w_duty = i_zero ? 8'd0 : (w_cnt == 8'd0) ? i_duty : r_duty;
    assign o_en   = r_en;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_en   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt;
            r_duty <= w_duty;
            r_en   <= w_cnt < w_duty;
        end
    end
endmodule

// File: rtl/line_follower_ctrl.sv
// line_follower_ctrl: debounced IR sensor bar -> weighted error -> steering FSM
// driving H-bridge pins, shared PWM enables and direction LEDs.
module line_follower_ctrl
    import lf_pkg::*;
#(
    parameter int N_SENSORS    = 5,
    parameter int PWM_PERIOD   = 100,
    parameter int DUTY_FWD     = 55,
    parameter int DUTY_TURN    = 40,
    parameter int DEBOUNCE     = 4,
    parameter int LOST_TIMEOUT = 5000
)(
    input logic clk,
    input logic rst_n,
    lf_if.master io
);
    localparam int C  = N_SENSORS / 2;
    localparam int EW = $clog2(N_SENSORS * C) + 2;
    localparam int TW = $clog2(LOST_TIMEOUT + 1);
    logic [N_SENSORS-1:0] r_sync1, r_sync2, r_last, r_deb;
    logic [7:0]           r_run, w_run, w_duty;
    logic                 r_vld, r_led_on, w_en;
    logic [TW-1:0]        r_timer;
    logic [3:0]           r_mot, w_mot;
    logic [2:0]           r_led_l, r_led_r, r_led_s, w_led_l, w_led_r, w_led_s;
    logic signed [EW-1:0] w_err;
    state_e               r_state, w_state_nxt;
    dir_e                 r_dir, w_dir_nxt;
    class_e               w_cls;
    // run length of the current synchronised value, saturating
    assign w_run = (r_sync2 != r_last) ? 8'd1 : r_run + {7'd0, r_run != 8'hFF};
    always_comb begin
        w_err = '0;
        for (int i = 0; i < N_SENSORS; i++)
            if (r_deb[i]) w_err = w_err + EW'(i - C);
    end
    assign w_cls = (r_deb == '0) ? CL_LOST : (&r_deb) ? CL_MARK :
                   w_err[EW-1] ? CL_LEFT : (w_err != '0) ? CL_RIGHT : CL_CENTRE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_mot       = MOT_OFF;
        w_led_l     = LED_OFF;
        w_led_r     = LED_OFF;
        w_led_s     = LED_OFF;
        w_duty      = 8'd0;
        if (r_state == ST_STOP)
            w_state_nxt = (w_cls == CL_CENTRE) ? ST_FWD : ST_STOP;
        else if (r_state != ST_IDLE || r_vld)
            w_state_nxt = (r_state == ST_SEARCH && w_cls == CL_LOST && r_timer == TW'(LOST_TIMEOUT - 1))
                          ? ST_STOP : class_target(w_cls);
        if (w_state_nxt == ST_TURN_L) w_dir_nxt = DIR_L;
        else if (w_state_nxt == ST_TURN_R) w_dir_nxt = DIR_R;
        case (w_state_nxt)
            ST_FWD:    begin w_mot = MOT_FWD;   w_led_s = LED_FULL; w_duty = 8'(DUTY_FWD);  end
            ST_TURN_L: begin w_mot = MOT_LEFT;  w_led_l = LED_FULL; w_duty = 8'(DUTY_TURN); end
            ST_TURN_R: begin w_mot = MOT_RIGHT; w_led_r = LED_FULL; w_duty = 8'(DUTY_TURN); end
            ST_SEARCH: begin
                w_mot   = (w_dir_nxt == DIR_L) ? MOT_LEFT : MOT_RIGHT;
                w_led_l = LED_SEARCH;
                w_led_r = LED_SEARCH;
                w_led_s = LED_SEARCH;
                w_duty  = 8'(DUTY_TURN);
            end
            ST_STOP:   begin w_led_l = LED_STOP; w_led_r = LED_STOP; w_led_s = LED_STOP; end
            default:   ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_last   <= '0;
            r_run    <= '0;
            r_deb    <= '0;
            r_vld    <= 1'b0;
            r_dir    <= DIR_L;
            r_timer  <= '0;
            r_mot    <= MOT_OFF;
            r_led_l  <= LED_OFF;
            r_led_r  <= LED_OFF;
            r_led_s  <= LED_OFF;
            r_led_on <= 1'b0;
        end else begin
            r_sync1  <= io.ir_sensor;
            r_sync2  <= r_sync1;
            r_last   <= r_sync2;
            r_run    <= w_run;
            if (w_run >= 8'(DEBOUNCE)) begin
                r_deb <= r_sync2;
                r_vld <= 1'b1;
            end
            r_dir    <= w_dir_nxt;
            r_timer  <= (r_state == ST_SEARCH) ? r_timer + 1'b1 : '0;
            r_mot    <= w_mot;
            r_led_l  <= w_led_l;
            r_led_r  <= w_led_r;
            r_led_s  <= w_led_s;
            r_led_on <= 1'b1;
        end
    end
    lf_pwm #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_duty (w_duty),
        .i_zero (w_state_nxt == ST_STOP),
        .o_en   (w_en)
    );
    assign {io.left_motor1, io.left_motor2, io.right_motor1, io.right_motor2} = r_mot;
    assign io.ena       = w_en;
    assign io.enb       = w_en;
    assign io.LED_LEFT  = r_led_l;
    assign io.LED_RIGHT = r_led_r;
    assign io.LED_STR   = r_led_s;
    assign io.LED_ON    = r_led_on;
endmodule

// File: tb/tb_line_follower_ctrl.sv
// tb_line_follower_ctrl: directed scenarios plus random sensor traffic against a
// cycle-level behavioural model of the line follower.
module tb_line_follower_ctrl;
    localparam int P = 100, DF = 55, DT = 40, D = 4, T = 50;
    localparam int S_IDLE = 0, S_FWD = 1, S_TL = 2, S_TR = 3, S_SRCH = 4, S_STOP = 5;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    lf_if #(.N_SENSORS(5)) bus();
    line_follower_ctrl #(.N_SENSORS(5), .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_TURN(DT),
                         .DEBOUNCE(D), .LOST_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
    int total = 0, bad = 0;
    int n, m_st, m_sidx, m_duty;
    bit m_vld, m_dir, m_en;
    logic [4:0] m_deb;
    logic [4:0] hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [3:0] mot();
        return {bus.left_motor1, bus.left_motor2, bus.right_motor1, bus.right_motor2};
    endfunction

    function automatic logic [15:0] got_v();
        return {mot(), bus.ena, bus.enb, bus.LED_LEFT, bus.LED_RIGHT, bus.LED_STR, bus.LED_ON};
    endfunction

    function automatic logic [15:0] exp_v();
        logic [3:0] mo;
        logic [8:0] led;
        mo  = (m_st == S_FWD) ? 4'b1010 : (m_st == S_TL) ? 4'b0110 : (m_st == S_TR) ? 4'b1001 :
              (m_st == S_SRCH) ? (m_dir ? 4'b1001 : 4'b0110) : 4'b0000;
        led = (m_st == S_FWD) ? 9'b000_000_111 : (m_st == S_TL) ? 9'b111_000_000 :
              (m_st == S_TR) ? 9'b000_111_000 : (m_st == S_SRCH) ? 9'b010_010_010 :
              (m_st == S_STOP) ? 9'b101_101_101 : 9'b0;
        return {mo, m_en, m_en, led, 1'b1};
    endfunction

    task automatic model_reset();
        n = 0; m_st = S_IDLE; m_sidx = 0; m_duty = 0;
        m_vld = 0; m_dir = 0; m_en = 0; m_deb = '0;
        hist = {5'd0, 5'd0};
    endtask

    // one rising edge: decide the state from the previous debounced vector, then debounce
    task automatic model_step(input logic [4:0] v);
        int e, tgt, nx;
        bit eq;
        n++;
        e = 0;
        for (int i = 0; i < 5; i++) if (m_deb[i]) e += i - 2;
        tgt = (m_deb == 5'd0) ? S_SRCH : (m_deb == 5'h1f) ? S_STOP :
              (e < 0) ? S_TL : (e > 0) ? S_TR : S_FWD;
        if (m_st == S_STOP) nx = (tgt == S_FWD) ? S_FWD : S_STOP;
        else if (m_st != S_IDLE || m_vld)
            nx = (m_st == S_SRCH && tgt == S_SRCH && n - m_sidx >= T) ? S_STOP : tgt;
        else nx = m_st;
        if (nx == S_SRCH && m_st != S_SRCH) m_sidx = n;
        if (nx == S_TL) m_dir = 0;
        else if (nx == S_TR) m_dir = 1;
        if (nx == S_STOP) m_duty = 0;
        else if (n % P == 0) m_duty = (nx == S_FWD) ? DF : (nx == S_IDLE) ? 0 : DT;
        m_en = (n % P) < m_duty;
        m_st = nx;
        hist.push_front(v);
        if (hist.size() > D + 2) void'(hist.pop_back());
        if (hist.size() == D + 2) begin
            eq = 1;
            for (int k = 3; k <= D + 1; k++) if (hist[k] != hist[2]) eq = 0;
            if (eq) begin m_deb = hist[2]; m_vld = 1; end
        end
    endtask

    task automatic cyc(input logic [4:0] v);
        bus.ir_sensor = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
        check("outs", {16'd0, got_v()}, {16'd0, exp_v()});
    endtask

    initial begin
        int hi, k, len;
        bit done;
        logic pe;
        logic [4:0] v;
        bus.ir_sensor = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", {16'd0, got_v()}, 32'd0);
        rst_n = 1'b1;
        repeat (6) cyc(5'b00100);
        check("lat6", {28'd0, mot()}, 32'd0);
        cyc(5'b00100);
        check("lat7", {25'd0, mot(), bus.LED_STR}, {25'd0, 4'b1010, 3'b111});
        while (n < 99) cyc(5'b00100);
        hi = 0;
        repeat (100) begin cyc(5'b00100); hi += int'(bus.ena); end
        check("duty_fwd", hi, 55);
        repeat (3) cyc(5'b10000);
        repeat (10) begin cyc(5'b00100); check("glitch", {28'd0, mot()}, {28'd0, 4'b1010}); end
        repeat (10) cyc(5'b00011);
        check("turn_l", {28'd0, mot()}, {28'd0, 4'b0110});
        repeat (200) cyc(5'b00011);
        hi = 0;
        repeat (100) begin cyc(5'b00011); hi += int'(bus.enb); end
        check("duty_turn", hi, 40);
        repeat (10) cyc(5'b11000);
        check("turn_r", {28'd0, mot()}, {28'd0, 4'b1001});
        hi = 0;
        repeat (70) begin
            cyc(5'b00000);
            if (mot() == 4'b1001 && bus.LED_STR == 3'b010 && bus.LED_LEFT == 3'b010) hi++;
        end
        check("search_len", hi, T);
        check("stop", {19'd0, mot(), bus.LED_LEFT, bus.LED_RIGHT, bus.LED_STR}, {19'd0, 13'b0000_101_101_101});
        repeat (10) cyc(5'b00110);
        check("sticky", {28'd0, mot()}, 32'd0);
        repeat (10) cyc(5'b00100);
        check("stop_exit", {28'd0, mot()}, {28'd0, 4'b1010});
        repeat (100) cyc(5'b00100);
        while (n % P != 10) cyc(5'b00100);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            pe = bus.ena;
            cyc(5'b11111);
            if (mot() == 4'b0000) begin
                check("stop_ena", {30'd0, pe, bus.ena}, 32'd2);
                done = 1;
            end
        end
        check("stop_seen", {31'd0, done}, 32'd1);
        repeat (150) begin
            v   = ($urandom_range(0, 2) == 0) ? 5'b00100 : 5'($urandom_range(0, 31));
            len = $urandom_range(1, 12);
            repeat (len) cyc(v);
        end
        repeat (20) cyc(5'b00100);
        k = 0;
        while (!(m_st == S_TL && m_en) && k < 300) begin cyc(5'b00011); k++; end
        check("tl_high", {31'd0, bus.ena}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {16'd0, got_v()}, 32'd0);
        model_reset();
        @(negedge clk);
        check("rst_hold", {16'd0, got_v()}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
